// File: rtl/gfx_mem_responder.sv
// Memory-side responder: queues texture reads, arbitrates them against framebuffer
// stores onto one fixed-latency memory port, and returns read data in request order.
module gfx_mem_responder #(
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        tex_req_valid,
    input  logic [31:0] tex_req_addr,
    input  logic [4:0]  tex_req_rd,
    output logic        tex_req_ready,
    output logic        tex_resp_valid,
    output logic [31:0] tex_resp_data,
    output logic [4:0]  tex_resp_rd,
    input  logic        gfx_st_valid,
    input  logic [31:0] gfx_st_addr,
    input  logic [31:0] gfx_st_wdata,
    input  logic [3:0]  gfx_st_wstrb,
    output logic        gfx_st_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_STORE = 1'b1
    } grant_e;

    logic [31:0]   fifo_addr_r [DEPTH];
    logic [4:0]    fifo_rd_r   [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    grant_e        last_grant_r;

    logic [MEM_LAT-1:0] pipe_v_r;
    logic [4:0]         pipe_rd_r [MEM_LAT];

    logic        resp_valid_r;
    logic [31:0] resp_data_r;
    logic [4:0]  resp_rd_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic hazard_s;
    logic rd_cand_s;
    logic st_cand_s;
    logic grant_read_s;
    logic grant_store_s;
    logic mem_hs_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // Store hazard: any occupied FIFO slot holding a read to the same word.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr_r} < count_r) &&
                (fifo_addr_r[i][31:2] == gfx_st_addr[31:2])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Candidate selection and round-robin tie-break against the last completed grant.
    always_comb begin
        rd_cand_s = rst_n && !empty_s && !flush;
        st_cand_s = rst_n && gfx_st_valid && !hazard_s;
        if (rd_cand_s && st_cand_s) begin
            grant_read_s = (last_grant_r == GRANT_STORE);
        end else begin
            grant_read_s = rd_cand_s;
        end
        grant_store_s = st_cand_s && !grant_read_s;
        mem_hs_s      = (rd_cand_s || st_cand_s) && mem_ready;
        pop_s         = grant_read_s && mem_ready;
        push_s        = rst_n && tex_req_valid && !full_s && !flush;
    end

    // Memory command mux driven by the current grant.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (grant_store_s) begin
            mem_we    = 1'b1;
            mem_addr  = gfx_st_addr;
            mem_wdata = gfx_st_wdata;
            mem_wstrb = gfx_st_wstrb;
        end else if (grant_read_s) begin
            mem_addr = fifo_addr_r[rd_ptr_r];
        end else begin
            mem_we = 1'b0;
        end
    end

    assign mem_valid     = rd_cand_s || st_cand_s;
    assign gfx_st_ready  = mem_ready && grant_store_s;
    assign tex_req_ready = rst_n && !full_s;
    assign busy          = rst_n && (!empty_s || (|pipe_v_r) || resp_valid_r);

    // Read request FIFO; a full cycle never pushes even when it also pops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i] <= 32'd0;
                fifo_rd_r[i]   <= 5'd0;
            end
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= tex_req_addr;
                fifo_rd_r[wr_ptr_r]   <= tex_req_rd;
                wr_ptr_r              <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Arbitration history advances only on an accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= GRANT_READ;
        end else if (mem_hs_s) begin
            last_grant_r <= grant_store_s ? GRANT_STORE : GRANT_READ;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Tag pipeline tracking accepted reads until their data returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v_r <= {MEM_LAT{1'b0}};
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_rd_r[i] <= 5'd0;
            end
        end else if (flush) begin
            pipe_v_r <= {MEM_LAT{1'b0}};
        end else begin
            pipe_v_r[0]  <= pop_s;
            pipe_rd_r[0] <= fifo_rd_r[rd_ptr_r];
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v_r[i]  <= pipe_v_r[i-1];
                pipe_rd_r[i] <= pipe_rd_r[i-1];
            end
        end
    end

    // Response register: captures returning data while the last tag stage is live.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'd0;
            resp_rd_r    <= 5'd0;
        end else if (flush) begin
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= pipe_v_r[MEM_LAT-1];
            if (pipe_v_r[MEM_LAT-1]) begin
                resp_data_r <= mem_rdata;
                resp_rd_r   <= pipe_rd_r[MEM_LAT-1];
            end else begin
                resp_data_r <= resp_data_r;
                resp_rd_r   <= resp_rd_r;
            end
        end
    end

    assign tex_resp_valid = rst_n && resp_valid_r;
    assign tex_resp_data  = rst_n ? resp_data_r : 32'd0;
    assign tex_resp_rd    = rst_n ? resp_rd_r : 5'd0;

endmodule

// File: tb/tb_gfx_mem_responder.sv
// Self-checking bench for gfx_mem_responder: memory device model plus an in-order
// scoreboard whose expected data is the word's value when the read was accepted.
module tb_gfx_mem_responder;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        tex_req_valid;
    logic [31:0] tex_req_addr;
    logic [4:0]  tex_req_rd;
    logic        tex_req_ready;
    logic        tex_resp_valid;
    logic [31:0] tex_resp_data;
    logic [4:0]  tex_resp_rd;
    logic        gfx_st_valid;
    logic [31:0] gfx_st_addr;
    logic [31:0] gfx_st_wdata;
    logic [3:0]  gfx_st_wstrb;
    logic        gfx_st_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    gfx_mem_responder #(.DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .tex_req_valid(tex_req_valid), .tex_req_addr(tex_req_addr), .tex_req_rd(tex_req_rd),
        .tex_req_ready(tex_req_ready), .tex_resp_valid(tex_resp_valid),
        .tex_resp_data(tex_resp_data), .tex_resp_rd(tex_resp_rd),
        .gfx_st_valid(gfx_st_valid), .gfx_st_addr(gfx_st_addr), .gfx_st_wdata(gfx_st_wdata),
        .gfx_st_wstrb(gfx_st_wstrb), .gfx_st_ready(gfx_st_ready),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic [4:0]  got_rd;
        logic [31:0] got_data;
        bit          unexp;
        int          cyc;
    } pair_t;

    logic [31:0] mem_dev [1024];
    logic [31:0] refmem  [1024];
    logic [31:0] rq      [LAT];
    exp_t        exp_q   [$];
    pair_t       pairs   [$];
    exp_t        mon_e;
    pair_t       mon_p;
    logic [31:0] mon_w;

    function automatic logic [31:0] init_word(int i);
        if (i == 0) return 32'h0000_2000;
        if (i == 8) return 32'h1122_3344;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Memory device: byte-strobed writes, reads returned LAT cycles after the handshake.
    assign mem_rdata = rq[LAT-1];
    initial begin
        forever begin
            @(posedge clk);
            if (mem_valid && mem_ready && mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem_dev[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
            for (int i = LAT - 1; i > 0; i--) rq[i] <= rq[i-1];
            rq[0] <= (mem_valid && mem_ready && !mem_we) ? mem_dev[mem_addr[11:2]] : 32'hBAD0_BAD0;
        end
    end

    // Scoreboard collector: pairs every response with the oldest live accepted read.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (tex_resp_valid) begin
                    mon_p.got_rd   = tex_resp_rd;
                    mon_p.got_data = tex_resp_data;
                    mon_p.cyc      = cyc;
                    mon_p.unexp    = (exp_q.size() == 0);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        mon_p.exp_rd   = mon_e.rd;
                        mon_p.exp_data = mon_e.data;
                    end
                    pairs.push_back(mon_p);
                end
                if (flush) exp_q.delete();
                if (gfx_st_valid && gfx_st_ready) begin
                    mon_w = refmem[gfx_st_addr[11:2]];
                    for (int b = 0; b < 4; b++) begin
                        if (gfx_st_wstrb[b]) mon_w[8*b +: 8] = gfx_st_wdata[8*b +: 8];
                    end
                    refmem[gfx_st_addr[11:2]] = mon_w;
                end
                if (tex_req_valid && tex_req_ready && !flush) begin
                    mon_e.rd   = tex_req_rd;
                    mon_e.data = refmem[tex_req_addr[11:2]];
                    exp_q.push_back(mon_e);
                end
            end
        end
    end

    function automatic int count_bad();
        int n = 0;
        foreach (pairs[i]) begin
            if (pairs[i].unexp || pairs[i].got_rd !== pairs[i].exp_rd ||
                pairs[i].got_data !== pairs[i].exp_data) n++;
        end
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush         = 1'b0;
        tex_req_valid = 1'b0;
        tex_req_addr  = 32'd0;
        tex_req_rd    = 5'd0;
        gfx_st_valid  = 1'b0;
        gfx_st_addr   = 32'd0;
        gfx_st_wdata  = 32'd0;
        gfx_st_wstrb  = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        mem_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tex_req_valid = 1'b1;
        gfx_st_valid  = 1'b1;
        mem_ready     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({tex_req_ready, gfx_st_ready, mem_valid, tex_resp_valid, busy, tex_resp_data, tex_resp_rd} !== 42'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %b, want all zero", k,
                         {tex_req_ready, gfx_st_ready, mem_valid, tex_resp_valid, busy});
            end
        end
        idle();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({tex_req_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release: ready/busy got %b want 10", {tex_req_ready, busy});
        end
    endtask

    task automatic test_single_read();
        pairs.delete();
        mem_ready     = 1'b1;
        tex_req_valid = 1'b1;
        tex_req_addr  = 32'h0000_1000;
        tex_req_rd    = 5'd7;
        #1;
        checks++;
        if (tex_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got %b want 1", tex_req_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            tex_req_valid = 1'b0;
            checks++;
            if (tex_resp_valid !== (k == 3)) begin
                failures++;
                $display("FAIL single_latency T+%0d: valid got %b want %b", k, tex_resp_valid, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if ({tex_resp_data, tex_resp_rd} !== {32'h0000_2000, 5'd7}) begin
                    failures++;
                    $display("FAIL single_data got %h/%0d want 00002000/7", tex_resp_data, tex_resp_rd);
                end
            end
        end
        checks++;
        if (pairs.size() != 1 || count_bad() != 0) begin
            failures++;
            $display("FAIL single_scoreboard got %0d responses (%0d bad) want 1 (0 bad)", pairs.size(), count_bad());
        end
    endtask

    task automatic test_fifo_full();
        int  i = 0;
        bit  gaps_ok = 1'b1;
        pairs.delete();
        mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tex_req_valid = 1'b1;
            tex_req_addr  = 32'h0000_1100 + 32'(4 * i);
            tex_req_rd    = 5'(10 + i);
            #1;
            checks++;
            if (tex_req_ready !== (c < 4)) begin
                failures++;
                $display("FAIL full_ready cycle %0d: got %b want %b", c, tex_req_ready, (c < 4));
            end
            if (tex_req_ready) i++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (tex_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_no_push: ready got %b want 0", tex_req_ready);
        end
        step();
        checks++;
        if (tex_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_after_pop: ready got %b want 1", tex_req_ready);
        end
        step();
        tex_req_valid = 1'b0;
        for (int k = 0; k < 12; k++) step();
        for (int j = 1; j < pairs.size(); j++) begin
            if (pairs[j].cyc != pairs[j-1].cyc + 1) gaps_ok = 1'b0;
        end
        checks++;
        if (pairs.size() != 5 || count_bad() != 0 || !gaps_ok) begin
            failures++;
            $display("FAIL full_order got %0d responses, %0d bad, back_to_back=%0d; want 5, 0, 1",
                     pairs.size(), count_bad(), gaps_ok);
        end
    endtask

    task automatic test_arbitration();
        int nacc = 0;
        do_reset();
        pairs.delete();
        gfx_st_valid  = 1'b1;
        gfx_st_addr   = 32'h0000_1800;
        gfx_st_wdata  = $urandom;
        gfx_st_wstrb  = 4'hF;
        tex_req_valid = 1'b1;
        tex_req_addr  = 32'h0000_1200;
        tex_req_rd    = 5'd1;
        for (int k = 0; k < 10; k++) begin
            mem_ready = (k >= 3);
            #1;
            if (k >= 1 && k <= 2) begin
                checks++;
                if ({mem_valid, mem_we} !== 2'b11) begin
                    failures++;
                    $display("FAIL arb_first_store cycle %0d: valid/we got %b want 11", k, {mem_valid, mem_we});
                end
            end
            if (k >= 3) begin
                checks++;
                if ({mem_we, mem_wstrb} !== (((k - 3) % 2 == 0) ? 5'b1_1111 : 5'b0_0000)) begin
                    failures++;
                    $display("FAIL arb_alternate cycle %0d: we/wstrb got %b want %b", k, {mem_we, mem_wstrb},
                             (((k - 3) % 2 == 0) ? 5'b1_1111 : 5'b0_0000));
                end
            end
            if (tex_req_ready) nacc++;
            step();
            if (tex_req_ready || nacc > 0) begin
                tex_req_addr = 32'h0000_1200 + 32'(4 * nacc);
                tex_req_rd   = 5'(nacc + 1);
            end
            gfx_st_wdata = $urandom;
        end
        idle();
        for (int k = 0; k < 15; k++) step();
        checks++;
        if (pairs.size() != nacc || count_bad() != 0) begin
            failures++;
            $display("FAIL arb_scoreboard got %0d responses (%0d bad) want %0d (0 bad)", pairs.size(), count_bad(), nacc);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        pairs.delete();
        mem_ready     = 1'b0;
        tex_req_valid = 1'b1;
        tex_req_addr  = 32'h0000_1004;
        tex_req_rd    = 5'd3;
        step();
        tex_req_valid = 1'b0;
        gfx_st_valid  = 1'b1;
        gfx_st_addr   = 32'h0000_1008;
        gfx_st_wdata  = 32'h5555_AAAA;
        gfx_st_wstrb  = 4'hF;
        mem_ready     = 1'b1;
        #1;
        checks++;
        if ({mem_we, gfx_st_ready, mem_addr} !== {2'b11, 32'h0000_1008}) begin
            failures++;
            $display("FAIL hazard_other_word: we/ready/addr got %b%b/%h want 11/00001008", mem_we, gfx_st_ready, mem_addr);
        end
        step();
        gfx_st_addr  = 32'h0000_1004;
        gfx_st_wdata = 32'hA5A5_A5A5;
        mem_ready    = 1'b0;
        #1;
        checks++;
        if ({mem_we, gfx_st_ready, mem_addr} !== {2'b00, 32'h0000_1004}) begin
            failures++;
            $display("FAIL hazard_block: we/ready/addr got %b%b/%h want 00/00001004", mem_we, gfx_st_ready, mem_addr);
        end
        step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_we, gfx_st_ready} !== 2'b00) begin
            failures++;
            $display("FAIL hazard_read_first: we/ready got %b want 00", {mem_we, gfx_st_ready});
        end
        step();
        checks++;
        if ({mem_we, gfx_st_ready} !== 2'b11) begin
            failures++;
            $display("FAIL hazard_store_next: we/ready got %b want 11", {mem_we, gfx_st_ready});
        end
        step();
        idle();
        tex_req_valid = 1'b1;
        tex_req_addr  = 32'h0000_1004;
        tex_req_rd    = 5'd4;
        step();
        tex_req_addr  = 32'h0000_1008;
        tex_req_rd    = 5'd5;
        step();
        tex_req_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (pairs.size() != 3 || count_bad() != 0) begin
            failures++;
            $display("FAIL hazard_scoreboard got %0d responses (%0d bad) want 3 (0 bad)", pairs.size(), count_bad());
        end else begin
            checks++;
            if ({pairs[0].got_data, pairs[1].got_data, pairs[2].got_data} !==
                {32'hC0DE_0001, 32'hA5A5_A5A5, 32'h5555_AAAA}) begin
                failures++;
                $display("FAIL hazard_values got %h %h %h want c0de0001 a5a5a5a5 5555aaaa",
                         pairs[0].got_data, pairs[1].got_data, pairs[2].got_data);
            end
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        do_reset();
        pairs.delete();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tex_req_valid = 1'b1;
            tex_req_addr  = 32'h0000_1040 + 32'(4 * i);
            tex_req_rd    = 5'(20 + i);
            step();
        end
        tex_req_valid = 1'b0;
        mem_ready     = 1'b1;
        step();
        flush         = 1'b1;
        tex_req_valid = 1'b1;
        tex_req_addr  = 32'h0000_1050;
        tex_req_rd    = 5'd23;
        #1;
        checks++;
        if ({mem_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL flush_cycle: mem_valid/busy got %b want 01", {mem_valid, busy});
        end
        step();
        idle();
        #1;
        checks++;
        if ({busy, tex_resp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL flush_idle: busy/resp got %b want 00", {busy, tex_resp_valid});
        end
        for (int k = 0; k < 6; k++) begin
            if (tex_resp_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen || pairs.size() != 0) begin
            failures++;
            $display("FAIL flush_no_resp: got %0d responses want 0", pairs.size());
        end
        tex_req_valid = 1'b1;
        tex_req_addr  = 32'h0000_1020;
        tex_req_rd    = 5'd9;
        step();
        tex_req_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (pairs.size() != 1 || count_bad() != 0) begin
            failures++;
            $display("FAIL flush_followup got %0d responses (%0d bad) want 1 (0 bad)", pairs.size(), count_bad());
        end else begin
            checks++;
            if ({pairs[0].got_data, pairs[0].got_rd} !== {32'h1122_3344, 5'd9}) begin
                failures++;
                $display("FAIL flush_followup_data got %h/%0d want 11223344/9", pairs[0].got_data, pairs[0].got_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        pairs.delete();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tex_req_valid = 1'b1;
            tex_req_addr  = 32'h0000_1060 + 32'(4 * i);
            tex_req_rd    = 5'(24 + i);
            step();
        end
        tex_req_valid = 1'b0;
        mem_ready     = 1'b1;
        step();
        rst_n         = 1'b0;
        tex_req_valid = 1'b1;
        gfx_st_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({tex_req_ready, gfx_st_ready, mem_valid, tex_resp_valid, busy, tex_resp_data, tex_resp_rd} !== 42'd0) begin
                failures++;
                $display("FAIL midreset_outputs cycle %0d: got %b want all zero", k,
                         {tex_req_ready, gfx_st_ready, mem_valid, tex_resp_valid, busy});
            end
            step();
        end
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if (tex_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready got %b want 1", tex_req_ready);
        end
        for (int k = 0; k < 8; k++) begin
            if (tex_resp_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen || pairs.size() != 0) begin
            failures++;
            $display("FAIL midreset_no_resp: got %0d responses want 0", pairs.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        pairs.delete();
        for (int c = 0; c < 400; c++) begin
            tex_req_valid = ($urandom_range(0, 99) < 60);
            tex_req_addr  = 32'h0000_1000 + ($urandom_range(0, 15) << 2);
            tex_req_rd    = 5'($urandom);
            gfx_st_valid  = ($urandom_range(0, 99) < 30);
            gfx_st_addr   = 32'h0000_1000 + ($urandom_range(0, 15) << 2);
            gfx_st_wdata  = $urandom;
            gfx_st_wstrb  = 4'($urandom);
            mem_ready     = ($urandom_range(0, 99) < 75);
            flush         = ($urandom_range(0, 99) < 3);
            #1;
            if (mem_valid && !mem_we) begin
                checks++;
                if ({gfx_st_ready, mem_wstrb, mem_wdata} !== 37'd0) begin
                    failures++;
                    $display("FAIL random_read_cmd cycle %0d: st_ready/wstrb/wdata got %b/%h/%h want 0", c,
                             gfx_st_ready, mem_wstrb, mem_wdata);
                end
            end
            step();
        end
        idle();
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (pairs.size() < 20 || count_bad() != 0) begin
            failures++;
            $display("FAIL random_scoreboard got %0d responses (%0d bad) want >=20 (0 bad)", pairs.size(), count_bad());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_dev[i] = init_word(i);
            refmem[i]  = init_word(i);
        end
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        idle();
        test_reset();
        test_single_read();
        test_fifo_full();
        test_arbitration();
        test_hazard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
